// File: rtl/riscv_cache_maint_ctrl.sv
// Whole-cache clean/invalidate sequencer: walks every set, writes back dirty ways, clears tag bits.
// Latency: 3 cycles per clean set (READ, CHECK, UPDATE) plus one DONE cycle; request-to-done_o = 3*SETS+1.
// Backpressure: evict_req_o holds each way until evict_ack_i; stall_o holds the pipeline for the whole walk.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   clean_i, invalidate_i          request pulses; merged into pending flags while a walk is running
//   busy_o, stall_o                walk in progress (identical)
//   idx_o, idx_vld_o               set index driven into tag/data memories, read strobe
//   dirty_i                        dirty bits of idx_o, valid the cycle after idx_vld_o
//   evict_req_o/evict_way_o/ack    write-back handshake with the BIU, one-hot way
//   upd_o, clr_dirty_o/clr_valid_o tag update strobe for every way of idx_o
//   done_o                         one-cycle end-of-walk pulse
// Optional feature macro RISCV_CACHE_MAINT_ABORT_EN adds abort_i / aborted_o.

module riscv_cache_maint_ctrl #(
  parameter int XLEN       = 32,
  parameter int SIZE       = 64,          // KB
  parameter int BLOCK_SIZE = XLEN,        // bits per line
  parameter int WAYS       = 2,
  localparam int SETS      = (SIZE * 1024 * 8) / (BLOCK_SIZE * WAYS),
  localparam int IDX_BITS  = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clean_i,
  input  logic                invalidate_i,
`ifdef RISCV_CACHE_MAINT_ABORT_EN
  input  logic                abort_i,
  output logic                aborted_o,
`endif
  output logic                busy_o,
  output logic                stall_o,
  output logic [IDX_BITS-1:0] idx_o,
  output logic                idx_vld_o,
  input  logic [WAYS-1:0]     dirty_i,
  output logic                evict_req_o,
  output logic [WAYS-1:0]     evict_way_o,
  input  logic                evict_ack_i,
  output logic                upd_o,
  output logic                clr_dirty_o,
  output logic                clr_valid_o,
  output logic                done_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_EVICT  = 3'd3;
  localparam logic [2:0] ST_UPDATE = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(SETS - 1);

  logic [2:0]          r_state;
  logic [IDX_BITS-1:0] r_idx;
  logic                r_cln;
  logic                r_inv;
  logic                r_pend_cln;
  logic                r_pend_inv;
  logic [WAYS-1:0]     r_mask;

  logic                w_busy;
  logic                w_start;
  logic [WAYS-1:0]     w_way;
  logic [WAYS-1:0]     w_mask_left;
  logic                w_finish;

  assign w_busy  = (r_state != ST_IDLE);
  // A walk starts from a fresh request or from requests parked during the previous walk.
  assign w_start = clean_i | invalidate_i | r_pend_cln | r_pend_inv;

  // Isolate the lowest outstanding way: x & -x.
  assign w_way       = r_mask & (~r_mask + WAYS'(1));
  assign w_mask_left = r_mask & ~w_way;

`ifdef RISCV_CACHE_MAINT_ABORT_EN
  logic r_abort;
  // Abort takes effect at the end of the current set's UPDATE, never mid-set.
  assign w_finish  = (r_idx == LAST_IDX) | r_abort | abort_i;
  assign aborted_o = (r_state == ST_DONE) & r_abort;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_abort <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_abort <= 1'b0;
    end else if (w_busy && abort_i) begin
      r_abort <= 1'b1;
    end
  end
`else
  assign w_finish = (r_idx == LAST_IDX);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_cln      <= 1'b0;
      r_inv      <= 1'b0;
      r_pend_cln <= 1'b0;
      r_pend_inv <= 1'b0;
      r_mask     <= '0;
    end else begin
      // Requests seen while busy (including the DONE cycle) are parked, not dropped.
      if (w_busy) begin
        r_pend_cln <= r_pend_cln | clean_i;
        r_pend_inv <= r_pend_inv | invalidate_i;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_cln      <= clean_i | r_pend_cln;
            r_inv      <= invalidate_i | r_pend_inv;
            r_pend_cln <= 1'b0;
            r_pend_inv <= 1'b0;
            r_idx      <= '0;
            r_state    <= ST_READ;
          end
        end
        ST_READ: begin
          r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          // Only a clean walk writes anything back; invalidate alone discards dirty data.
          if (r_cln && (dirty_i != '0)) begin
            r_mask  <= dirty_i;
            r_state <= ST_EVICT;
          end else begin
            r_state <= ST_UPDATE;
          end
        end
        ST_EVICT: begin
          if (evict_ack_i) begin
            r_mask <= w_mask_left;
            if (w_mask_left == '0) begin
              r_state <= ST_UPDATE;
            end
          end
        end
        ST_UPDATE: begin
          if (w_finish) begin
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + IDX_BITS'(1);
            r_state <= ST_READ;
          end
        end
        ST_DONE: begin
          r_idx   <= '0;
          r_state <= ST_IDLE;
`ifdef RISCV_CACHE_MAINT_ABORT_EN
          if (r_abort) begin
            r_pend_cln <= 1'b0;
            r_pend_inv <= 1'b0;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = w_busy;
  assign stall_o     = w_busy;
  assign idx_o       = r_idx;
  assign idx_vld_o   = (r_state == ST_READ);
  assign evict_req_o = (r_state == ST_EVICT);
  assign evict_way_o = (r_state == ST_EVICT) ? w_way : '0;
  assign upd_o       = (r_state == ST_UPDATE);
  assign clr_dirty_o = (r_state == ST_UPDATE) & r_cln;
  assign clr_valid_o = (r_state == ST_UPDATE) & r_inv;
  assign done_o      = (r_state == ST_DONE);

endmodule

// File: tb/tb_riscv_cache_maint_ctrl.sv
module tb_riscv_cache_maint_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       clean_i = 1'b0;
  logic       invalidate_i = 1'b0;
  logic [1:0] dirty_i = 2'b00;
  logic       evict_ack_i = 1'b0;
  logic       busy_o, stall_o, idx_vld_o, evict_req_o, upd_o, clr_dirty_o, clr_valid_o, done_o;
  logic [1:0] idx_o;
  logic [1:0] evict_way_o;
  logic       w_aborted;
`ifdef RISCV_CACHE_MAINT_ABORT_EN
  logic       abort_i = 1'b0;
  logic       aborted_o;
  assign w_aborted = aborted_o;
`else
  assign w_aborted = 1'b0;
`endif

  // SIZE=1KB, 1024-bit lines, 2 ways -> 4 sets
  riscv_cache_maint_ctrl #(.XLEN(32), .SIZE(1), .BLOCK_SIZE(1024), .WAYS(2)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clean_i      (clean_i),
    .invalidate_i (invalidate_i),
`ifdef RISCV_CACHE_MAINT_ABORT_EN
    .abort_i      (abort_i),
    .aborted_o    (aborted_o),
`endif
    .busy_o       (busy_o),
    .stall_o      (stall_o),
    .idx_o        (idx_o),
    .idx_vld_o    (idx_vld_o),
    .dirty_i      (dirty_i),
    .evict_req_o  (evict_req_o),
    .evict_way_o  (evict_way_o),
    .evict_ack_i  (evict_ack_i),
    .upd_o        (upd_o),
    .clr_dirty_o  (clr_dirty_o),
    .clr_valid_o  (clr_valid_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        cln;
    logic        inv;
    logic [1:0]  dirty;
    logic        ack;
    logic        ab;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [12:0] w_dut;
  assign w_dut = {w_aborted, busy_o, stall_o, idx_vld_o, upd_o, clr_dirty_o, clr_valid_o,
                  done_o, evict_req_o, evict_way_o, idx_o};

  function automatic logic [12:0] ow(input logic ab, input logic busy, input logic vld,
                                     input logic upd, input logic cd, input logic cv,
                                     input logic dn, input logic er, input logic [1:0] ew,
                                     input logic [1:0] idx);
    return {ab, busy, busy, vld, upd, cd, cv, dn, er, ew, idx};
  endfunction

  task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic push(input logic c, input logic v, input logic [1:0] d, input logic a,
                      input logic ab, input logic [12:0] e);
    vec_t t;
    t.cln = c; t.inv = v; t.dirty = d; t.ack = a; t.ab = ab; t.exp = e;
    vecs.push_back(t);
  endtask

  // One set with no write-back: READ, CHECK, UPDATE.
  task automatic add_set(input logic [1:0] idx, input logic [1:0] d, input logic cd,
                         input logic cv, input logic inj_inv, input logic ab);
    push(1'b0, inj_inv, 2'b00, 1'b0, ab,
         ow(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, idx));
    push(1'b0, 1'b0, d, 1'b0, 1'b0,
         ow(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, idx));
    push(1'b0, 1'b0, 2'b00, 1'b0, 1'b0,
         ow(1'b0, 1'b1, 1'b0, 1'b1, cd, cv, 1'b0, 1'b0, 2'b00, idx));
  endtask

  // Idle request cycle, 4 sets, DONE. Optional invalidate during set 1 READ and clean in DONE.
  task automatic add_walk(input logic c, input logic v, input logic [1:0] d, input logic inj,
                          input logic cd, input logic cv, input logic done_c);
    push(c, v, 2'b00, 1'b0, 1'b0, 13'd0);
    for (int s = 0; s < 4; s++) add_set(2'(s), d, cd, cv, inj && (s == 1), 1'b0);
    push(done_c, 1'b0, 2'b00, 1'b0, 1'b0,
         ow(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'd3));
  endtask

  task automatic add_idle();
    push(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 13'd0);
  endtask

  logic [1:0] ways[2];
  logic       seen;
  int         dones;

  initial begin
    // clean, nothing dirty: done_o 13 cycles after the request cycle
    add_walk(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    add_idle();
    // clean with set 2 fully dirty, ack two cycles after each request; stray ack in CHECK
    add_idle();
    push(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 13'd0);
    add_set(2'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    add_set(2'd1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, ow(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd2));
    push(1'b0, 1'b0, 2'b11, 1'b1, 1'b0, ow(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd2));
    ways[0] = 2'b01;
    ways[1] = 2'b10;
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 3; k++)
        push(1'b0, 1'b0, 2'b00, (k == 2), 1'b0,
             ow(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ways[w], 2'd2));
    push(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, ow(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd2));
    add_set(2'd3, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, ow(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'd3));
    add_idle();
    // invalidate with dirty lines: no write-back; clean arriving in DONE starts a clean walk
    add_walk(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    add_walk(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    add_idle();
    // clean, invalidate mid-walk -> second walk with invalidate only
    add_walk(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    add_walk(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    add_idle();
    // both requests together: one walk clearing both bits
    add_walk(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    add_idle();
    add_idle();
`ifdef RISCV_CACHE_MAINT_ABORT_EN
    // abort in set 1 READ: set 1 completes, no set 2, parked invalidate dropped
    push(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 13'd0);
    add_set(2'd0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    add_set(2'd1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, ow(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'd1));
    add_idle();
    add_idle();
    add_idle();
`endif

    // reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_state", w_dut, 13'd0);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk_i);
      #1;
      clean_i      = vecs[i].cln;
      invalidate_i = vecs[i].inv;
      dirty_i      = vecs[i].dirty;
      evict_ack_i  = vecs[i].ack;
`ifdef RISCV_CACHE_MAINT_ABORT_EN
      abort_i      = vecs[i].ab;
`endif
      @(negedge clk_i);
      check($sformatf("vec%0d", i), w_dut, vecs[i].exp);
    end

    // reset while evicting at idx 1
    @(posedge clk_i);
    #1;
    clean_i = 1'b1;
    invalidate_i = 1'b0;
    evict_ack_i = 1'b0;
    dirty_i = 2'b00;
`ifdef RISCV_CACHE_MAINT_ABORT_EN
    abort_i = 1'b0;
`endif
    @(posedge clk_i);
    #1;
    clean_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      dirty_i = (idx_o == 2'd1) ? 2'b01 : 2'b00;
      @(negedge clk_i);
      if (evict_req_o && idx_o == 2'd1) seen = 1'b1;
      else begin
        @(posedge clk_i);
        #1;
      end
    end
    check("evict_idx1_reached", {12'd0, seen}, 13'd1);
    rst_ni = 1'b0;
    dirty_i = 2'b00;
    #1;
    check("reset_mid_evict", w_dut, 13'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    dones = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    check("no_done_after_reset", 13'(dones), 13'd0);
    check("idle_after_reset", w_dut, 13'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
